full_adder_4b: RTL and testbench
================================

# full_adder_4b

Registered 4-bit binary adder with carry-in, carry-out and signed-overflow flag, built as a ripple chain of 1-bit full-adder cells. It is the arithmetic core of the 4-bit BCD adder stage, which consumes `y`/`Co` and applies the +6 decimal correction downstream. The block captures one operand pair per clock when `in_valid` is high and presents the sum one cycle later.

## Interface
- No parameters; width fixed at 4 bits.
- Clocking: one clock; reset is asynchronous and active-low.
- Port declaration order: `clk, rst_n, Co, y, a, b, ci, in_valid, out_valid, ovf` (+ `bcd_adj` when enabled).
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `Co` output 1: registered carry-out of the sum (bit 4).
- `y` output 4: registered sum bits [3:0].
- `a` input 4: operand A, unsigned (two's complement for `ovf`).
- `b` input 4: operand B.
- `ci` input 1: carry-in.
- `in_valid` input 1: operands valid this cycle; capture enable.
- `out_valid` output 1: `y`/`Co`/`ovf` hold a result from a captured operation.
- `ovf` output 1: registered signed overflow.
- `bcd_adj` output 1: present only with `FULL_ADDER_4B_BCD_FLAG_EN`; registered decimal-correction request.

## Operation
- Combinational path: four 1-bit full-adder cells in ripple. Cell i: s_i = a_i ^ b_i ^ c_i, c_(i+1) = a_i·b_i | c_i·(a_i ^ b_i). c_0 = `ci`.
- Result: {Co, y} = a + b + ci, exact 5-bit, no saturation. Maximum 15+15+1 = 31 → `Co`=1, `y`=1111.
- `ovf` = (a[3] == b[3]) && (sum[3] != a[3]), i.e. c_4 ^ c_3.
- On a rising edge with `in_valid`=1: register `y`, `Co`, `ovf` (and `bcd_adj`); set `out_valid`=1.
- On a rising edge with `in_valid`=0: all result registers hold their values; `out_valid`=0.
- No back-pressure; every valid input is accepted and produces exactly one `out_valid` pulse.
- Inputs with X/Z are not supported; X propagation is not masked.

## Timing
- Latency: 1 clock from the `in_valid` edge to `out_valid`/result. Throughput: 1 operation per clock.
- Back-to-back valid inputs give a continuous `out_valid`, with results in input order.
- Reset (`rst_n`=0, asynchronous, takes effect immediately): `y`=0000, `Co`=0, `ovf`=0, `out_valid`=0, `bcd_adj`=0.
- Reset mid-operation: the in-flight result is discarded. The first edge after deassertion with `in_valid`=1 captures normally.
- No combinational path from inputs to outputs.

## Configuration
- `FULL_ADDER_4B_BCD_FLAG_EN` defined: adds output `bcd_adj`, registered with `in_valid` like the other results.
  - `bcd_adj` = (sum > 9) || carry-out, where sum is the 4-bit sum bits [3:0] and carry-out is bit 4.
  - It signals the downstream BCD stage to add 6 and force the decimal carry.
- Not defined: `bcd_adj` port and logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert `rst_n`=0 with random inputs and `in_valid`=1 → `y`=0000, `Co`=0, `ovf`=0, `out_valid`=0 immediately and while held.
- a=0110, b=0110, ci=0, one valid cycle → next cycle `y`=1100, `Co`=0, `ovf`=1, `out_valid`=1 for one cycle; `bcd_adj`=1 if enabled.
- a=1111, b=0001, ci=0 → `y`=0000, `Co`=1, `ovf`=0; a=1111, b=1111, ci=1 → `y`=1111, `Co`=1, `ovf`=0.
- Back-to-back: (0011+0100, ci=0), then (0111+0001, ci=1), then `in_valid`=0 → `y`=0111 then 1001, `out_valid` high 2 cycles, then low with `y`=1001 held; `bcd_adj` 0 then 0 (9 is not >9).
- Reset mid-stream: `rst_n` low one cycle after a valid 1000+1000 → outputs 0, no `out_valid` pulse for that operation; next valid 0101+0101 → `y`=1010, `Co`=0, `ovf`=1.
- Exhaustive sweep: all 512 (a, b, ci) combinations → {Co, y} = a+b+ci and `ovf`/`bcd_adj` match the formulas.

Source files
------------

// File: rtl/full_adder_4b.sv
// Registered 4-bit ripple-carry adder with carry-out and signed-overflow flag.
// Define FULL_ADDER_4B_BCD_FLAG_EN to add the registered bcd_adj output for the downstream BCD stage.

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ c_in;
    assign c_out    = (a & b) | (c_in & half_sum);

endmodule

module full_adder_4b (
    input  logic       clk,
    input  logic       rst_n,
    output logic       Co,
    output logic [3:0] y,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    input  logic       in_valid,
    output logic       out_valid,
    output logic       ovf
`ifdef FULL_ADDER_4B_BCD_FLAG_EN
    ,
    output logic       bcd_adj
`endif
);

    logic [4:0] carry;
    logic [3:0] sum;
    logic       ovf_next;

    assign carry[0] = ci;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_cell
            full_adder_cell u_cell (
                .a     (a[i]),
                .b     (b[i]),
                .c_in  (carry[i]),
                .s     (sum[i]),
                .c_out (carry[i+1])
            );
        end
    endgenerate

    // Signed overflow occurs exactly when the carries into and out of the sign bit differ.
    assign ovf_next = carry[4] ^ carry[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= 4'b0000;
            Co        <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y   <= sum;
                Co  <= carry[4];
                ovf <= ovf_next;
            end
        end
    end

`ifdef FULL_ADDER_4B_BCD_FLAG_EN
    logic bcd_next;

    // A 4-bit sum above 9 means bit 3 plus either bit 2 or bit 1; a carry-out also needs +6.
    assign bcd_next = carry[4] | (sum[3] & (sum[2] | sum[1]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_adj <= 1'b0;
        end else if (in_valid) begin
            bcd_adj <= bcd_next;
        end
    end
`endif

endmodule

// File: tb/tb_full_adder_4b.sv
// Directed and exhaustive self-checking bench for full_adder_4b.
// Also exercises bcd_adj when built with FULL_ADDER_4B_BCD_FLAG_EN.

module tb_full_adder_4b;

    logic       clk;
    logic       rst_n;
    logic       Co;
    logic [3:0] y;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic       in_valid;
    logic       out_valid;
    logic       ovf;
`ifdef FULL_ADDER_4B_BCD_FLAG_EN
    logic       bcd_adj;
`endif

    int checks = 0;
    int passes = 0;

    full_adder_4b dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Co        (Co),
        .y         (y),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .in_valid  (in_valid),
        .out_valid (out_valid),
        .ovf       (ovf)
`ifdef FULL_ADDER_4B_BCD_FLAG_EN
        ,
        .bcd_adj   (bcd_adj)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkResult(input string tag, input logic [3:0] exp_y, input logic exp_co,
                               input logic exp_ovf, input logic exp_bcd, input logic exp_valid);
        checkOutput({tag, "_y"}, 8'(y), 8'(exp_y));
        checkOutput({tag, "_co"}, 8'(Co), 8'(exp_co));
        checkOutput({tag, "_ovf"}, 8'(ovf), 8'(exp_ovf));
        checkOutput({tag, "_valid"}, 8'(out_valid), 8'(exp_valid));
`ifdef FULL_ADDER_4B_BCD_FLAG_EN
        checkOutput({tag, "_bcd"}, 8'(bcd_adj), 8'(exp_bcd));
`else
        if (exp_bcd === 1'bx) $display("[TB] unexpected X in expected bcd flag");
`endif
    endtask

    task automatic applyStimulus(input logic [3:0] a_in, input logic [3:0] b_in,
                                 input logic ci_in, input logic valid_in);
        a        = a_in;
        b        = b_in;
        ci       = ci_in;
        in_valid = valid_in;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b1;
        a        = 4'($urandom);
        b        = 4'($urandom);
        ci       = 1'($urandom);
        #1;
        rst_n = 1'b0;
        #1;
        checkResult("reset_now", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
            checkResult("reset_held", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;

        applyStimulus(4'b0110, 4'b0110, 1'b0, 1'b1);
        checkResult("six_six", 4'b1100, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkResult("six_six_hold", 4'b1100, 1'b0, 1'b1, 1'b1, 1'b0);

        applyStimulus(4'b1111, 4'b0001, 1'b0, 1'b1);
        checkResult("wrap", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b1);
        checkResult("max", 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1);

        applyStimulus(4'b0011, 4'b0100, 1'b0, 1'b1);
        checkResult("b2b_first", 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0111, 4'b0001, 1'b1, 1'b1);
        checkResult("b2b_second", 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkResult("b2b_idle", 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset lands while 1000+1000 is pending, so that operation must never appear.
        a        = 4'b1000;
        b        = 4'b1000;
        ci       = 1'b0;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkResult("midrst_async", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkResult("midrst_edge", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(4'b0101, 4'b0101, 1'b0, 1'b1);
        checkResult("after_rst", 4'b1010, 1'b0, 1'b1, 1'b1, 1'b1);

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int c = 0; c < 2; c++) begin
                    logic [3:0] av;
                    logic [3:0] bv;
                    logic [4:0] total;
                    logic       exp_ovf;
                    logic       exp_bcd;
                    av      = 4'(ai);
                    bv      = 4'(bi);
                    total   = 5'(ai + bi + c);
                    exp_ovf = (av[3] == bv[3]) && (total[3] != av[3]);
                    exp_bcd = (total[3:0] > 4'd9) || total[4];
                    applyStimulus(av, bv, 1'(c), 1'b1);
                    checkOutput($sformatf("sweep_sum_%0d_%0d_%0d", ai, bi, c), 8'({Co, y}), 8'(total));
                    checkOutput($sformatf("sweep_ovf_%0d_%0d_%0d", ai, bi, c), 8'(ovf), 8'(exp_ovf));
                    checkOutput("sweep_valid", 8'(out_valid), 8'b1);
`ifdef FULL_ADDER_4B_BCD_FLAG_EN
                    checkOutput($sformatf("sweep_bcd_%0d_%0d_%0d", ai, bi, c), 8'(bcd_adj), 8'(exp_bcd));
`else
                    if (exp_bcd === 1'bx) $display("[TB] unexpected X in expected bcd flag");
`endif
                end
            end
        end

        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkResult("final_idle", 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
